// File: rtl/count_sequencer.sv
// count_sequencer: run controller for a clear/increment counter.
// A run is started with a terminal value and a pass count. Each pass clears
// the counter, then counts up to the terminal value. Completion is reported
// with done and a cancelled run with aborted. Both are single-cycle pulses.
module count_sequencer #(
  parameter int WIDTH  = 6,
  parameter int PASS_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  limit,
  input  logic [PASS_W-1:0] passes,
  input  logic              hold,
  input  logic              abort,
  input  logic [WIDTH-1:0]  cnt_value,
  output logic              cnt_clr,
  output logic              cnt_en,
  output logic              busy,
  output logic              pass_done,
  output logic [PASS_W-1:0] passes_done,
  output logic              done,
  output logic              aborted
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [PASS_W-1:0] PASS_ZERO = {PASS_W{1'b0}};
  localparam logic [PASS_W-1:0] PASS_ONE  = {{(PASS_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  LIM_ZERO  = {WIDTH{1'b0}};

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [WIDTH-1:0]  limit_r;
  logic [PASS_W-1:0] passes_r;
  logic [PASS_W-1:0] passes_done_r;
  logic [PASS_W-1:0] passes_inc_s;
  logic              busy_r;
  logic              done_r;
  logic              aborted_r;
  logic              capture_s;
  logic              abort_hit_s;
  logic              cnt_clr_s;
  logic              cnt_en_s;
  logic              pass_done_s;

  // A zero pass request is treated as a single pass.
  function automatic logic [PASS_W-1:0] clamp_passes(input logic [PASS_W-1:0] p);
    if (p == PASS_ZERO) begin
      return PASS_ONE;
    end else begin
      return p;
    end
  endfunction

  assign passes_inc_s = passes_done_r + PASS_ONE;

  // Next-state and counter control decode; abort outranks the terminal test.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    abort_hit_s = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_en_s    = 1'b0;
    pass_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        cnt_clr_s = 1'b1;
        if (abort) begin
          abort_hit_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          abort_hit_s = 1'b1;
          cnt_clr_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (cnt_value == limit_r) begin
          pass_done_s = 1'b1;
          if (passes_inc_s == passes_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CLEAR;
          end
        end else begin
          cnt_en_s    = ~hold;
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, captured request and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      limit_r       <= LIM_ZERO;
      passes_r      <= PASS_ZERO;
      passes_done_r <= PASS_ZERO;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      aborted_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      busy_r    <= (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_RUN);
      done_r    <= (state_nxt_s == ST_DONE);
      aborted_r <= abort_hit_s;
      if (capture_s) begin
        limit_r       <= limit;
        passes_r      <= clamp_passes(passes);
        passes_done_r <= PASS_ZERO;
      end else if (pass_done_s && (passes_done_r != passes_r)) begin
        passes_done_r <= passes_inc_s;
      end else begin
        passes_done_r <= passes_done_r;
      end
    end
  end

  assign cnt_clr     = cnt_clr_s;
  assign cnt_en      = cnt_en_s;
  assign pass_done   = pass_done_s;
  assign busy        = busy_r;
  assign done        = done_r;
  assign aborted     = aborted_r;
  assign passes_done = passes_done_r;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural counter.
// Each run records per-cycle outputs into bit masks. Bit c of a mask is
// cycle c, where the start cycle is cycle 0. The masks are compared with
// hand-derived values.
module tb_count_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] limit = 6'd0;
  logic [3:0] passes = 4'd0;
  logic       hold = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] cnt_value = 6'd0;
  logic       cnt_clr;
  logic       cnt_en;
  logic       busy;
  logic       pass_done;
  logic [3:0] passes_done;
  logic       done;
  logic       aborted;

  int checks = 0;
  int errors = 0;

  logic [63:0] en_v, clr_v, pd_v, dn_v, busy_v, ab_v;
  logic [3:0]  pdn_l [64];
  logic [5:0]  cv_l  [64];

  count_sequencer #(.WIDTH(6), .PASS_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .limit(limit),
    .passes(passes), .hold(hold), .abort(abort), .cnt_value(cnt_value),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .busy(busy), .pass_done(pass_done),
    .passes_done(passes_done), .done(done), .aborted(aborted)
  );

  always #5 clock = ~clock;

  // Counter being controlled: clear wins over increment.
  always @(posedge clock) begin
    if (cnt_clr) cnt_value <= 6'd0;
    else if (cnt_en) cnt_value <= cnt_value + 6'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs n cycles: start in cycle 0, and an optional extra start pulse.
  // The limit and passes inputs change after cycle 0 to show they are
  // captured at start. Hold, abort and reset are applied in chosen cycles.
  task automatic run(input logic [5:0] lim, input logic [3:0] np,
                     input int hold_a, input int hold_b, input int abort_at,
                     input int start_extra, input int reset_at, input int n);
    en_v = 64'd0; clr_v = 64'd0; pd_v = 64'd0;
    dn_v = 64'd0; busy_v = 64'd0; ab_v = 64'd0;
    for (int c = 0; c < n; c++) begin
      @(posedge clock); #1;
      start  = (c == 0) || (c == start_extra);
      limit  = (c == 0) ? lim : 6'd63;
      passes = (c == 0) ? np : 4'd9;
      hold   = (c >= hold_a) && (c <= hold_b);
      abort  = (c == abort_at);
      reset  = (c == reset_at);
      @(negedge clock);
      en_v[c] = cnt_en; clr_v[c] = cnt_clr; pd_v[c] = pass_done;
      dn_v[c] = done; busy_v[c] = busy; ab_v[c] = aborted;
      pdn_l[c] = passes_done; cv_l[c] = cnt_value;
    end
    start = 1'b0; hold = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_outs", {58'd0, cnt_clr, cnt_en, busy, pass_done, done, aborted}, 64'd0);
    chk("reset_passes_done", {60'd0, passes_done}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Basic run: limit=3, passes=1, extra start while in DONE (cycle 6)
    run(6'd3, 4'd1, -1, -1, -1, 6, -1, 10);
    chk("basic_clr", clr_v, 64'h2);
    chk("basic_en", en_v, 64'h1C);
    chk("basic_pd", pd_v, 64'h20);
    chk("basic_done", dn_v, 64'h40);
    chk("basic_busy", busy_v, 64'h3E);
    chk("basic_pdn", {60'd0, pdn_l[6]}, 64'd1);
    chk("basic_excl", en_v & clr_v, 64'd0);

    // Multi-pass: limit=2, passes=3, ignored start in cycle 7
    run(6'd2, 4'd3, -1, -1, -1, 7, -1, 16);
    chk("multi_pd", pd_v, 64'h1110);
    chk("multi_done", dn_v, 64'h2000);
    chk("multi_clr", clr_v, 64'h222);
    chk("multi_en", en_v, 64'hCCC);
    chk("multi_busy", busy_v, 64'h1FFE);
    chk("multi_pdn", {52'd0, pdn_l[5], pdn_l[9], pdn_l[13]}, {52'd0, 4'd1, 4'd2, 4'd3});

    // limit=0, passes=0: one pass with no increments
    run(6'd0, 4'd0, -1, -1, -1, -1, -1, 6);
    chk("zero_pd", pd_v, 64'h4);
    chk("zero_done", dn_v, 64'h8);
    chk("zero_en", en_v, 64'd0);
    chk("zero_pdn", {60'd0, pdn_l[3]}, 64'd1);

    // passes=15, limit=1: done in cycle 46
    run(6'd1, 4'd15, -1, -1, -1, -1, -1, 50);
    chk("max_done", dn_v, 64'h0000_4000_0000_0000);
    chk("max_pd_count", 64'($countones(pd_v)), 64'd15);
    chk("max_busy", busy_v, 64'h0000_3FFF_FFFF_FFFE);
    chk("max_pdn", {60'd0, pdn_l[46]}, 64'd15);

    // Hold in cycles 3-4: counter frozen and done delayed to cycle 8
    run(6'd3, 4'd1, 3, 4, -1, -1, -1, 10);
    chk("hold_en", en_v, 64'h64);
    chk("hold_pd", pd_v, 64'h80);
    chk("hold_done", dn_v, 64'h100);
    chk("hold_cv", {52'd0, cv_l[3], cv_l[4]}, {52'd0, 6'd1, 6'd1});

    // Abort in cycle 3 of a limit=10 run, with an ignored start in cycle 2
    run(6'd10, 4'd1, -1, -1, 3, 2, -1, 8);
    chk("abort_clr", clr_v, 64'hA);
    chk("abort_en", en_v, 64'h4);
    chk("abort_pulse", ab_v, 64'h10);
    chk("abort_done", dn_v, 64'd0);
    chk("abort_busy", busy_v, 64'hE);
    chk("abort_pdn", {60'd0, pdn_l[7]}, 64'd0);

    // Synchronous reset in cycle 4 of a limit=1, passes=3 run
    run(6'd1, 4'd3, -1, -1, -1, -1, 4, 8);
    chk("rst_busy", busy_v, 64'h1E);
    chk("rst_clr", clr_v, 64'h12);
    chk("rst_en", en_v, 64'h4);
    chk("rst_pd", pd_v, 64'h8);
    chk("rst_done", dn_v, 64'd0);
    chk("rst_pdn", {56'd0, pdn_l[4], pdn_l[5]}, {56'd0, 4'd1, 4'd0});

    // Fresh start after reset: limit=2, passes=1
    run(6'd2, 4'd1, -1, -1, -1, -1, -1, 8);
    chk("fresh_done", dn_v, 64'h20);
    chk("fresh_en", en_v, 64'hC);
    chk("fresh_pd", pd_v, 64'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
